ps2_tx_apb: RTL and testbench

PS2_TX_APB -- requirements
Module: ps2_tx_apb

---
 rtl/ps2_tx_apb.sv | 185 ++++++++++++++++++
 tb/tb_ps2_tx_apb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx_apb.sv
// PS/2 device-side transmitter with an APB slave front end and a small TX FIFO.
// Bytes written to TXDATA are framed (start, 8 data LSB first, odd parity, stop) on ps2_clk/ps2_data.
module ps2_tx_apb #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic        ps2_clk,
  output logic        ps2_data
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = 9;
  localparam logic [PW-1:0] HALF = PW'(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  phase, phase_next;
  logic [3:0]     bit_idx, bit_next;
  logic           pop;
  logic [7:0]     tx_byte;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, empty;
  logic           access, complete, sel_tx, sel_st, sel_ct;
  logic           push, flush;
  logic [31:0]    status;
  logic           frame_bit, clk_next, data_next;
  logic           unused_inputs;

  assign unused_inputs = &{1'b0, in_pprot, in_paddr[31:4], in_pwdata[31:8], in_pstrb[3:1]};

  // APB decode; every side effect is qualified by complete (psel & penable & pready)
  assign access   = in_psel & in_penable;
  assign complete = access & in_pready;
  assign sel_tx   = (in_paddr[3:0] == 4'h0);
  assign sel_st   = (in_paddr[3:0] == 4'h4);
  assign sel_ct   = (in_paddr[3:0] == 4'h8);

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign push       = complete & in_pwrite & sel_tx & in_pstrb[0] & ~full;
  assign flush      = complete & in_pwrite & sel_ct & in_pwdata[0];
  assign in_pslverr = complete & in_pwrite & sel_tx & in_pstrb[0] & full;

  always_comb begin
    status      = '0;
    status[0]   = (state != IDLE);
    status[1]   = full;
    status[2]   = empty;
    status[7:4] = 4'(count);
  end

  assign in_prdata = (complete & ~in_pwrite & sel_st) ? status : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         in_pready <= 1'b0;
    else if (complete) in_pready <= 1'b0;
    else if (access)   in_pready <= 1'b1;
  end

  // FIFO storage and pointers; flush overrides a coincident pop
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_pwdata[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    tx_byte <= '0;
    else if (pop) tx_byte <= mem[rd_ptr];
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_idx <= bit_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    phase_next = phase;
    bit_next   = bit_idx;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SHIFT;
          phase_next = '0;
          bit_next   = '0;
        end
      end
      SHIFT: begin
        if (phase == LAST) begin
          phase_next = '0;
          if (bit_idx == 4'd10) state_next = GAP;
          else                  bit_next   = bit_idx + 4'd1;
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      GAP: begin
        if (phase == LAST) begin
          phase_next = '0;
          bit_next   = '0;
          if (!empty) begin
            pop        = 1'b1;
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs, registered below so the pins are glitch-free
  always_comb begin
    unique case (bit_idx)
      4'd0:    frame_bit = 1'b0;
      4'd9:    frame_bit = ~^tx_byte;
      4'd10:   frame_bit = 1'b1;
      default: frame_bit = tx_byte[3'(bit_idx - 4'd1)];
    endcase
    clk_next  = 1'b1;
    data_next = 1'b1;
    if (state == SHIFT) begin
      clk_next  = (phase < HALF);
      data_next = frame_bit;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      ps2_clk  <= clk_next;
      ps2_data <= data_next;
    end
  end

endmodule

// File: tb/tb_ps2_tx_apb.sv
// Directed bench for ps2_tx_apb: APB stimulus, scoreboard of expected bytes, ps2 line monitor.
module tb_ps2_tx_apb;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BIT_CYC    = 2 * CLK_DIV;
  localparam int unsigned PERIOD     = 24 * CLK_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic [2:0]  in_pprot = '0;
  logic        in_pwrite = 1'b0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = '0;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic        ps2_clk;
  logic        ps2_data;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned frames = 0;
  logic [7:0]  sb[$];
  int unsigned starts[$];

  ps2_tx_apb #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
    .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
    .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
    .in_pslverr(in_pslverr), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                     output int unsigned nw, output int unsigned done);
    @(posedge clock); #1;
    in_psel = 1'b1; in_penable = 1'b0; in_pwrite = wr;
    in_paddr = addr; in_pwdata = wdata; in_pstrb = strb;
    @(posedge clock); #1;
    in_penable = 1'b1;
    nw = 0;
    while (!in_pready && nw < 16) begin
      @(posedge clock); #1;
      nw++;
    end
    rdata = in_prdata;
    err   = in_pslverr;
    @(posedge clock); #1;
    done = cyc;
    chk("pready_drop", in_pready, 1'b0);
    in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
  endtask

  task automatic wait_start(input int unsigned n_before);
    int unsigned t = 0;
    while (starts.size() <= n_before && t < 100) begin
      @(posedge clock); t++;
    end
    #1 chk("frame_start", starts.size() > n_before, 1'b1);
  endtask

  task automatic wait_frames(input int unsigned target, input int unsigned budget);
    int unsigned t = 0;
    while (frames < target && t < budget) begin
      @(posedge clock); t++;
    end
    #1 chk("frame_done", frames, target);
  endtask

  // Line monitor: decodes each frame and checks every cycle against the scoreboard head
  initial begin : monitor
    logic [10:0] bits;
    logic [7:0]  exp_b;
    logic        aborted;
    logic        prev;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && prev && !ps2_data && ps2_clk) begin
        starts.push_back(cyc);
        chk("sb_has_entry", sb.size() != 0, 1'b1);
        exp_b   = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        bits    = {1'b1, ~^exp_b, exp_b, 1'b0};
        aborted = 1'b0;
        for (int k = 0; k < 11; k++) begin
          for (int c = 0; c < int'(BIT_CYC); c++) begin
            if (!aborted) begin
              if (k != 0 || c != 0) @(negedge clock);
              if (reset) aborted = 1'b1;
              else begin
                chk("ps2_data_bit", ps2_data, bits[k]);
                chk("ps2_clk_phase", ps2_clk, c < int'(CLK_DIV));
              end
            end
          end
        end
        if (!aborted) begin
          @(negedge clock);
          if (!reset) begin
            chk("gap_clk", ps2_clk, 1'b1);
            chk("gap_data", ps2_data, 1'b1);
            frames++;
          end
        end
      end
      prev = ps2_data;
    end
  end

  initial begin : main
    logic [31:0] rd;
    logic        err;
    int unsigned nw, done, f0, n0, base, s;
    logic [7:0]  b;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_ps2_clk", ps2_clk, 1'b1);
    chk("rst_ps2_data", ps2_data, 1'b1);
    chk("rst_pready", in_pready, 1'b0);
    chk("rst_pslverr", in_pslverr, 1'b0);
    chk("rst_prdata", in_prdata, 32'h0);
    reset = 1'b0;

    apb(1'b0, 32'h4, 32'h0, 4'h0, rd, err, nw, done);
    chk("status_idle", rd, 32'h4);
    chk("wait_states", nw, 1);
    chk("status_err", err, 1'b0);

    apb(1'b0, 32'hC, 32'h0, 4'h0, rd, err, nw, done);
    chk("rd_other", rd, 32'h0);
    chk("rd_other_err", err, 1'b0);
    apb(1'b1, 32'hC, 32'hFF, 4'hF, rd, err, nw, done);
    chk("wr_other_err", err, 1'b0);
    apb(1'b1, 32'h0, 32'hAA, 4'hE, rd, err, nw, done);
    chk("strb0_err", err, 1'b0);
    apb(1'b0, 32'h4, 32'h0, 4'h0, rd, err, nw, done);
    chk("status_after_noop", rd, 32'h4);

    // single frames with fixed expected bit patterns
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? 8'h1C : 8'hF0;
      n0 = starts.size();
      f0 = frames;
      sb.push_back(b);
      apb(1'b1, 32'h0, {24'h0, b}, 4'h1, rd, err, nw, done);
      chk("tx_err", err, 1'b0);
      wait_start(n0);
      if (starts.size() > n0) chk("start_latency", starts[$] - done, 2);
      wait_frames(f0 + 1, PERIOD + 20);
      repeat (BIT_CYC + 4) @(posedge clock);
      #1 chk("pslverr_idle", in_pslverr, 1'b0);
    end

    // burst: 1st byte pops at once, next 4 fill the FIFO, 6th overflows
    n0 = starts.size();
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      b = 8'hA1 + 8'(i);
      if (i < 5) sb.push_back(b);
      apb(1'b1, 32'h0, {24'h0, b}, 4'h1, rd, err, nw, done);
      chk("burst_err", err, i == 5);
    end
    apb(1'b0, 32'h4, 32'h0, 4'h0, rd, err, nw, done);
    chk("status_full", rd, 32'h43);
    wait_frames(f0 + 5, 5 * PERIOD + 100);
    base = n0;
    for (int i = 1; i < 5; i++) begin
      if (starts.size() > base + i) chk("frame_spacing", starts[base + i] - starts[base + i - 1], PERIOD);
    end
    repeat (BIT_CYC + 8) @(posedge clock);
    apb(1'b0, 32'h4, 32'h0, 4'h0, rd, err, nw, done);
    chk("status_back_idle", rd, 32'h4);

    // flush during the first of three queued frames
    f0 = frames;
    n0 = starts.size();
    sb.push_back(8'h3C);
    apb(1'b1, 32'h0, 32'h3C, 4'h1, rd, err, nw, done);
    apb(1'b1, 32'h0, 32'h5A, 4'h1, rd, err, nw, done);
    apb(1'b1, 32'h0, 32'h77, 4'h1, rd, err, nw, done);
    apb(1'b1, 32'h8, 32'h1, 4'hF, rd, err, nw, done);
    chk("ctrl_err", err, 1'b0);
    apb(1'b0, 32'h4, 32'h0, 4'h0, rd, err, nw, done);
    chk("status_flushed", rd, 32'h5);
    repeat (3 * PERIOD + 40) @(posedge clock);
    #1;
    chk("flush_frames", frames, f0 + 1);
    chk("flush_starts", starts.size(), n0 + 1);
    apb(1'b0, 32'h4, 32'h0, 4'h0, rd, err, nw, done);
    chk("status_after_flush", rd, 32'h4);

    // reset 30 cycles into a frame of 0x00 (bit 3, clock low, data low)
    n0 = starts.size();
    f0 = frames;
    sb.push_back(8'h00);
    apb(1'b1, 32'h0, 32'h00, 4'h1, rd, err, nw, done);
    wait_start(n0);
    s = (starts.size() > n0) ? starts[$] : cyc;
    while (cyc < s + 30) @(posedge clock);
    #2;
    chk("pre_rst_clk", ps2_clk, 1'b0);
    chk("pre_rst_data", ps2_data, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_clk", ps2_clk, 1'b1);
    chk("async_rst_data", ps2_data, 1'b1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (200) @(posedge clock);
    #1;
    chk("no_frame_after_rst", starts.size(), n0 + 1);
    chk("aborted_not_counted", frames, f0);
    chk("sb_drained", sb.size(), 0);
    apb(1'b0, 32'h4, 32'h0, 4'h0, rd, err, nw, done);
    chk("status_after_rst", rd, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
